// File: rtl/detector_seq_ctrl.sv
// detector_seq_ctrl: framed byte-serial pattern matcher with per-frame match counting.
// Define DETECT_OVERLAP_EN to count overlapping matches (default: non-overlapping).
module detector_seq_ctrl #(
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               busy,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [7:0] sreg;
  logic last_r;
  logic [2:0] idx;
  logic [PAT_MAX-1:0] hist, pat, hist_n, mask;
  logic [3:0] len, fill, fill_n;
  logic [4:0] fill_inc;
  logic accept, cfg_ok, hit;
  assign accept = in_valid && in_ready;
  assign cfg_ok = cfg_we && !busy && state == IDLE && cfg_len != 4'd0 && cfg_len <= 4'(PAT_MAX);
  always_comb begin
    hist_n   = {hist[PAT_MAX-2:0], sreg[7]};
    fill_inc = {1'b0, fill} + 5'd1;
    mask     = ~({PAT_MAX{1'b1}} << len);
    hit      = state == SHIFT && fill_inc >= {1'b0, len} && ((hist_n ^ pat) & mask) == '0;
`ifdef DETECT_OVERLAP_EN
    fill_n   = fill_inc > {1'b0, len} ? len : fill_inc[3:0];
`else
    fill_n   = hit ? 4'd0 : fill_inc > {1'b0, len} ? len : fill_inc[3:0];
`endif
  end
  always_comb begin
    state_n = state == IDLE  ? (accept ? SHIFT : IDLE) :
              state == SHIFT ? (idx == 3'd7 ? (last_r ? DONE : IDLE) : SHIFT) : IDLE;
  end
  always_comb begin
    in_ready = state == IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      match_pulse <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
      hist        <= '0;
      fill        <= '0;
      pat         <= PAT_MAX'(3'b010);
      len         <= 4'd3;
      sreg        <= '0;
      last_r      <= 1'b0;
      idx         <= '0;
    end else begin
      state       <= state_n;
      match_pulse <= hit;
      done        <= state == DONE;
      if (cfg_ok) begin
        pat <= cfg_pattern;
        len <= cfg_len;
      end
      if (accept) begin
        sreg   <= in_data;
        last_r <= in_last;
        idx    <= '0;
      end
      // frame start: matcher state is wiped so nothing leaks from the previous frame
      if (accept && !busy) begin
        hist        <= '0;
        fill        <= '0;
        match_count <= '0;
        busy        <= 1'b1;
      end
      if (state == SHIFT) begin
        sreg <= {sreg[6:0], 1'b0};
        idx  <= idx + 3'd1;
        hist <= hist_n;
        fill <= fill_n;
        if (hit && !(&match_count)) match_count <= match_count + 1'b1;
      end
      if (state == DONE) busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_detector_seq_ctrl.sv
// tb_detector_seq_ctrl: directed vectors for the framed pattern detector.
module tb_detector_seq_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, cfg_we = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] cfg_pattern = '0, in_data = '0;
  logic [3:0] cfg_len = '0;
  logic in_ready, busy, match_pulse, done;
  logic [7:0] match_count;
  logic s_ready, s_busy, s_pulse, s_done;
  logic [1:0] s_count;
  int total = 0, passes = 0, pulses = 0, s_pulses = 0, cyc = 0, last_pulse_cyc = -1;
`ifdef DETECT_OVERLAP_EN
  localparam int OV = 1;
`else
  localparam int OV = 0;
`endif
  detector_seq_ctrl #(.PAT_MAX(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .busy(busy), .match_pulse(match_pulse), .match_count(match_count), .done(done)
  );
  detector_seq_ctrl #(.PAT_MAX(8), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(s_ready), .in_data(in_data), .in_last(in_last),
    .busy(s_busy), .match_pulse(s_pulse), .match_count(s_count), .done(s_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (match_pulse) begin
      pulses++;
      last_pulse_cyc = cyc;
    end
    if (s_pulse) s_pulses++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  typedef struct {
    logic [7:0] d;
    int         exp_cnt;
  } vec_t;
  vec_t vt[6];
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    check("ready_before_send", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask
  task automatic cfg(input logic [7:0] p, input logic [3:0] l);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_we      = 1'b1;
    tick();
    cfg_we      = 1'b0;
  endtask
  initial begin
    int n, p0, sp0, acc, seen;
    vt[0] = '{8'h52, 2 + OV};
    vt[1] = '{8'hAA, 2 + OV};
    vt[2] = '{8'h00, 0};
    vt[3] = '{8'hFF, 0};
    vt[4] = '{8'h12, 2};
    vt[5] = '{8'h49, 2};
    tick();
    tick();
    check("rst_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(match_count), 0);
    check("rst_done", int'(done), 0);
    check("rst_pulse", int'(match_pulse), 0);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      p0 = pulses;
      send(vt[i].d, 1'b1);
      wait_done(n);
      check($sformatf("done_latency_%02h", vt[i].d), n, 9);
      check($sformatf("count_%02h", vt[i].d), int'(match_count), vt[i].exp_cnt);
      check($sformatf("pulses_%02h", vt[i].d), pulses - p0, vt[i].exp_cnt);
      check($sformatf("busy_at_done_%02h", vt[i].d), int'(busy), 0);
      tick();
      check($sformatf("done_one_cycle_%02h", vt[i].d), int'(done), 0);
      check($sformatf("count_hold_%02h", vt[i].d), int'(match_count), vt[i].exp_cnt);
    end
    // pattern 1001 straddling bytes 0x02 | 0x40
    cfg(8'h09, 4'd4);
    p0 = pulses;
    send(8'h02, 1'b0);
    n = 0;
    while (!in_ready && n < 20) begin
      n++;
      tick();
    end
    check("ready_low_byte1", n, 8);
    check("busy_between_bytes", int'(busy), 1);
    send(8'h40, 1'b1);
    acc = cyc;
    wait_done(n);
    check("xbyte_pulses", pulses - p0, 1);
    check("xbyte_count", int'(match_count), 1);
    check("xbyte_pulse_time", last_pulse_cyc - acc, 2);
    tick();
    cfg(8'h01, 4'd1);
    p0 = pulses;
    sp0 = s_pulses;
    send(8'hFF, 1'b1);
    wait_done(n);
    check("sat_pulses", s_pulses - sp0, 8);
    check("sat_count", int'(s_count), 3);
    check("wide_count", int'(match_count), 8);
    check("wide_pulses", pulses - p0, 8);
    tick();
    // write during SHIFT must be dropped
    cfg(8'h02, 4'd3);
    send(8'hFF, 1'b1);
    cfg(8'h03, 4'd2);
    wait_done(n);
    check("guard_latency", n, 8);
    check("guard_count", int'(match_count), 0);
    tick();
    cfg(8'h03, 4'd0);
    send(8'h52, 1'b1);
    wait_done(n);
    check("len0_ignored_count", int'(match_count), 2 + OV);
    tick();
    cfg(8'h01, 4'd1);
    send(8'h52, 1'b1);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_ready", int'(in_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_count", int'(match_count), 0);
    check("abort_done", int'(done), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    send(8'h52, 1'b1);
    wait_done(n);
    check("post_reset_count", int'(match_count), 2 + OV);
    tick();
    send(8'h00, 1'b0);
    n = 0;
    while (!in_ready && n < 20) begin
      n++;
      tick();
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) seen++;
      tick();
    end
    check("stall_busy_low_cycles", seen, 0);
    check("stall_no_done", int'(done), 0);
    send(8'h02, 1'b1);
    wait_done(n);
    check("stall_latency", n, 9);
    check("stall_count", int'(match_count), 1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
